// File: rtl/shop_arbiter.sv
// Round-robin arbiter/sequencer sharing one shop purchase datapath among N_REQ players.
// One transaction runs IDLE->ISSUE->WAIT->DONE; result returned as a one-cycle done pulse.
module shop_arbiter #(
  parameter int N_REQ = 2,
  parameter int CNT_W = 16,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [3*N_REQ-1:0]  req_action,
  input  logic [10*N_REQ-1:0] req_credit,
  output logic               busy,
  output logic               done_valid,
  output logic [IW-1:0]      done_id,
  output logic [1:0]         done_status,
  output logic [9:0]         done_credit,
  output logic [4:0]         done_grant,
  output logic               shop_buy_valid,
  output logic [2:0]         shop_action,
  output logic [9:0]         shop_credit,
  input  logic               shop_success,
  input  logic               shop_err_invalid,
  input  logic               shop_err_credit,
  input  logic               shop_err_oos,
  input  logic [9:0]         shop_credit_out,
  input  logic [4:0]         shop_grant,
  output logic [CNT_W-1:0]   txn_count,
  output logic [CNT_W-1:0]   success_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_INV = 2'd1;
  localparam logic [1:0] ST_CR  = 2'd2;
  localparam logic [1:0] ST_OOS = 2'd3;

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_q, id_q, pick_id, done_id_q;
  logic              pick_vld;
  logic [2:0]        act_q;
  logic [9:0]        cred_q, done_credit_q;
  logic [1:0]        status_q, status_d, done_status_q;
  logic [4:0]        done_grant_q;
  logic [CNT_W-1:0]  txn_q, succ_q;
  int                idx;

  // Search starts at rr_q and wraps; first asserted request wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = IW'(idx);
      end
    end
  end

  // No flag at all is treated as an invalid action.
  always_comb begin
    if (shop_success)          status_d = ST_OK;
    else if (shop_err_invalid) status_d = ST_INV;
    else if (shop_err_credit)  status_d = ST_CR;
    else if (shop_err_oos)     status_d = ST_OOS;
    else                       status_d = ST_INV;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q          <= '0;
      id_q          <= '0;
      act_q         <= '0;
      cred_q        <= '0;
      status_q      <= '0;
      done_id_q     <= '0;
      done_status_q <= '0;
      done_credit_q <= '0;
      done_grant_q  <= '0;
      txn_q         <= '0;
      succ_q        <= '0;
    end else begin
      case (state_q)
        IDLE: if (pick_vld) begin
          id_q   <= pick_id;
          act_q  <= req_action[3*int'(pick_id) +: 3];
          cred_q <= req_credit[10*int'(pick_id) +: 10];
        end
        ISSUE: status_q <= status_d;
        // Shop credit/grant are registered on its side, so they are valid here.
        WAIT: begin
          done_id_q     <= id_q;
          done_status_q <= status_q;
          done_credit_q <= shop_credit_out;
          done_grant_q  <= shop_grant;
        end
        DONE: begin
          txn_q <= txn_q + 1'b1;
          if (done_status_q == ST_OK) succ_q <= succ_q + 1'b1;
          rr_q  <= (int'(id_q) == N_REQ-1) ? '0 : id_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy           = (state_q != IDLE);
  assign done_valid     = (state_q == DONE);
  assign done_id        = done_id_q;
  assign done_status    = done_status_q;
  assign done_credit    = done_credit_q;
  assign done_grant     = done_grant_q;
  assign shop_buy_valid = (state_q == ISSUE);
  assign shop_action    = act_q;
  assign shop_credit    = cred_q;
  assign txn_count      = txn_q;
  assign success_count  = succ_q;

endmodule

// File: tb/tb_shop_arbiter.sv
// Bench for shop_arbiter: behavioural shop plus a round-robin/stock reference model.
module tb_shop_arbiter;
  localparam int N  = 3;
  localparam int CW = 16;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req;
  logic [2:0] act [N];
  logic [9:0] cred [N];
  logic [3*N-1:0] req_action;
  logic [10*N-1:0] req_credit;
  logic busy, done_valid, shop_buy_valid;
  logic [IW-1:0] done_id;
  logic [1:0] done_status;
  logic [9:0] done_credit, shop_credit, shop_credit_out;
  logic [4:0] done_grant, shop_grant;
  logic [2:0] shop_action;
  logic shop_success, shop_err_invalid, shop_err_credit, shop_err_oos;
  logic [CW-1:0] txn_count, success_count;

  int n_chk = 0, n_fail = 0, cyc = 0, last_lat = 0;
  int price [5] = '{10, 40, 50, 30, 20};
  int stock [5];
  int ref_rr, ref_txn, ref_succ;
  int ref_stock [5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_pk
    assign req_action[3*g +: 3]  = act[g];
    assign req_credit[10*g +: 10] = cred[g];
  end

  shop_arbiter #(.N_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_action(req_action), .req_credit(req_credit),
    .busy(busy), .done_valid(done_valid), .done_id(done_id), .done_status(done_status),
    .done_credit(done_credit), .done_grant(done_grant), .shop_buy_valid(shop_buy_valid),
    .shop_action(shop_action), .shop_credit(shop_credit), .shop_success(shop_success),
    .shop_err_invalid(shop_err_invalid), .shop_err_credit(shop_err_credit),
    .shop_err_oos(shop_err_oos), .shop_credit_out(shop_credit_out), .shop_grant(shop_grant),
    .txn_count(txn_count), .success_count(success_count));

  function automatic int pr(input logic [2:0] a);
    return (a < 5) ? price[a] : 0;
  endfunction

  // Shop environment: flags combinational, credit/grant registered; credit and OOS may both fire.
  always_comb begin
    shop_err_invalid = shop_buy_valid && (shop_action >= 5);
    shop_err_credit  = shop_buy_valid && (shop_action < 5) && (int'(shop_credit) < pr(shop_action));
    shop_err_oos     = shop_buy_valid && (shop_action < 5) && (stock[shop_action < 5 ? shop_action : 0] == 0);
    shop_success     = shop_buy_valid && !shop_err_invalid && !shop_err_credit && !shop_err_oos;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) stock[i] <= 5;
      shop_credit_out <= '0;
      shop_grant      <= '0;
    end else if (shop_buy_valid) begin
      if (shop_success) begin
        stock[shop_action] <= stock[shop_action] - 1;
        shop_credit_out    <= shop_credit - 10'(pr(shop_action));
        shop_grant         <= 5'(1 << shop_action);
      end else begin
        shop_credit_out <= shop_credit;
        shop_grant      <= '0;
      end
    end
  end

  task automatic model_reset();
    ref_rr = 0; ref_txn = 0; ref_succ = 0;
    for (int i = 0; i < 5; i++) ref_stock[i] = 5;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  // Waits for a done pulse and checks it against the reference model.
  task automatic serve(input bit drop, output int who);
    int n = 0, w = -1, es, ec, eg;
    do begin @(negedge clk); n++; end while (!done_valid && n < 20);
    last_lat = n;
    n_chk++;
    if (!done_valid) begin
      $display("FAIL done_timeout: no done_valid within %0d cycles", n);
      n_fail++; who = -1; return;
    end
    for (int k = 0; k < N; k++) if (w < 0 && req[(ref_rr + k) % N]) w = (ref_rr + k) % N;
    if (w < 0) w = 0;
    if (act[w] >= 5)                 begin es = 1; ec = cred[w]; eg = 0; end
    else if (cred[w] < price[act[w]]) begin es = 2; ec = cred[w]; eg = 0; end
    else if (ref_stock[act[w]] == 0) begin es = 3; ec = cred[w]; eg = 0; end
    else begin es = 0; ec = cred[w] - price[act[w]]; eg = 1 << act[w]; end
    n_chk++;
    if (done_id !== IW'(w)) begin
      $display("FAIL done_id: got %0d expected %0d", done_id, w); n_fail++; end
    n_chk++;
    if (done_status !== 2'(es)) begin
      $display("FAIL done_status: got %0d expected %0d (player %0d)", done_status, es, w); n_fail++; end
    n_chk++;
    if (done_credit !== 10'(ec)) begin
      $display("FAIL done_credit: got %0d expected %0d", done_credit, ec); n_fail++; end
    n_chk++;
    if (done_grant !== 5'(eg)) begin
      $display("FAIL done_grant: got %b expected %b", done_grant, 5'(eg)); n_fail++; end
    if (es == 0) begin ref_stock[act[w]]--; ref_succ++; end
    ref_txn++;
    ref_rr = (w + 1) % N;
    if (drop) req[w] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (done_valid !== 1'b0 || txn_count !== CW'(ref_txn) || success_count !== CW'(ref_succ)) begin
      $display("FAIL post_done: valid=%b txn=%0d succ=%0d expected 0/%0d/%0d",
               done_valid, txn_count, success_count, ref_txn, ref_succ);
      n_fail++;
    end
    who = w;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0;
    for (int i = 0; i < N; i++) begin act[i] = '0; cred[i] = '0; end
    model_reset();
    @(negedge clk); @(negedge clk);
    n_chk++;
    if ({busy, done_valid, shop_buy_valid, shop_action, shop_credit, done_credit, done_grant,
         done_status, txn_count, success_count} !== '0) begin
      $display("FAIL reset_state: busy=%b dv=%b bv=%b act=%0d txn=%0d", busy, done_valid,
               shop_buy_valid, shop_action, txn_count);
      n_fail++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int w;
    act[0] = 3'd1; cred[0] = 10'd100; req[0] = 1'b1;
    @(negedge clk);
    n_chk++;
    if (shop_buy_valid !== 1'b1 || shop_action !== 3'd1 || shop_credit !== 10'd100) begin
      $display("FAIL issue_phase: bv=%b act=%0d cr=%0d expected 1/1/100", shop_buy_valid, shop_action, shop_credit);
      n_fail++;
    end
    @(negedge clk);
    n_chk++;
    if (shop_buy_valid !== 1'b0 || shop_action !== 3'd1 || busy !== 1'b1) begin
      $display("FAIL wait_phase: bv=%b act=%0d busy=%b expected 0/1/1", shop_buy_valid, shop_action, busy);
      n_fail++;
    end
    serve(1'b1, w);
    n_chk++;
    if (last_lat != 1) begin
      $display("FAIL latency: done %0d cycles after wait, expected 1", last_lat); n_fail++; end
    n_chk++;
    if (done_status !== 2'd0 || done_credit !== 10'd60 || done_grant !== 5'b00010 || done_id !== '0) begin
      $display("FAIL single_hold: st=%0d cr=%0d gr=%b id=%0d expected 0/60/00010/0",
               done_status, done_credit, done_grant, done_id);
      n_fail++;
    end
  endtask

  task automatic test_alternate();
    int w, t0;
    int exp_ids [4] = '{0, 1, 0, 1};
    pulse_reset();
    act[0] = 3'd3; cred[0] = 10'd500; act[1] = 3'd4; cred[1] = 10'd500;
    t0 = cyc;
    req = 3'b011;
    for (int i = 0; i < 4; i++) begin
      serve(i == 3, w);
      n_chk++;
      if (w != exp_ids[i]) begin
        $display("FAIL alternate_id[%0d]: got %0d expected %0d", i, w, exp_ids[i]); n_fail++; end
    end
    req = '0;
    n_chk++;
    if (cyc - t0 != 16 || txn_count !== CW'(4)) begin
      $display("FAIL alternate_rate: cycles=%0d txn=%0d expected 16/4", cyc - t0, txn_count); n_fail++; end
  endtask

  task automatic test_errors();
    int w;
    int succ0;
    succ0 = ref_succ;
    act[0] = 3'd2; cred[0] = 10'd10; req[0] = 1'b1;
    serve(1'b1, w);
    n_chk++;
    if (done_status !== 2'd2 || done_credit !== 10'd10 || done_grant !== '0 || success_count !== CW'(succ0)) begin
      $display("FAIL credit_err: st=%0d cr=%0d gr=%b succ=%0d", done_status, done_credit, done_grant, success_count);
      n_fail++;
    end
    act[1] = 3'd6; cred[1] = 10'd77; req[1] = 1'b1;
    serve(1'b1, w);
    n_chk++;
    if (done_status !== 2'd1 || done_credit !== 10'd77 || done_grant !== '0) begin
      $display("FAIL invalid_act: st=%0d cr=%0d gr=%b expected 1/77/0", done_status, done_credit, done_grant);
      n_fail++;
    end
  endtask

  task automatic test_oos();
    int w;
    act[2] = 3'd0; cred[2] = 10'd1000;
    for (int i = 0; i < 6; i++) begin
      req[2] = 1'b1;
      serve(1'b1, w);
      n_chk++;
      if (done_status !== ((i < 5) ? 2'd0 : 2'd3)) begin
        $display("FAIL oos_seq[%0d]: status %0d", i, done_status); n_fail++; end
    end
    n_chk++;
    if (done_grant !== '0) begin
      $display("FAIL oos_grant: got %b expected 00000", done_grant); n_fail++; end
  endtask

  task automatic test_reset_mid();
    int w;
    bit saw = 1'b0;
    act[1] = 3'd4; cred[1] = 10'd300; req[1] = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if (txn_count !== '0 || success_count !== '0 || shop_action !== '0 || shop_credit !== '0 ||
        busy !== 1'b0 || done_credit !== '0) begin
      $display("FAIL reset_mid: txn=%0d succ=%0d act=%0d busy=%b", txn_count, success_count, shop_action, busy);
      n_fail++;
    end
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (done_valid) saw = 1'b1; end
    rst = 1'b0;
    model_reset();
    n_chk++;
    if (saw) begin $display("FAIL reset_abort: done_valid seen during reset"); n_fail++; end
    serve(1'b1, w);
    n_chk++;
    if (w != 1 || done_status !== 2'd0 || done_credit !== 10'd280) begin
      $display("FAIL reset_recover: id=%0d st=%0d cr=%0d expected 1/0/280", w, done_status, done_credit);
      n_fail++;
    end
  endtask

  task automatic test_random();
    int w, cnt;
    for (int r = 0; r < 30; r++) begin
      if (r % 10 == 0) pulse_reset();
      for (int i = 0; i < N; i++) begin
        act[i]  = 3'($urandom_range(0, 7));
        cred[i] = 10'($urandom_range(0, 1023));
      end
      req = N'($urandom_range(1, (1 << N) - 1));
      cnt = $countones(req);
      for (int j = 0; j < cnt; j++) serve(1'b1, w);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_errors();
    test_oos();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
